// File: rtl/conv_input_loader.sv
// conv_input_loader: packs a header, 1-bit pixel rows and a terminator into SRAM words.
// Latency: each word is written in the cycle after the handshake or state that produces it.
// Backpressure: cfg_ready only in IDLE; pix_ready only in ROWS and low during a row write.
// Optional macro LOADER_AUTORUN_EN: after the terminator, pulse dut_run and wait out dut_busy.
module conv_input_loader (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [4:0]  cfg_nrows,
    input  logic [4:0]  cfg_ncols,
    input  logic        cfg_last,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_data,
    output logic [11:0] ld_sram_write_address,
    output logic [15:0] ld_sram_write_data,
    output logic        ld_sram_write_enable,
    output logic        dut_run,
    input  logic        dut_busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [3:0] {
        IDLE, HDR_R, HDR_C, ROWS, TERM, RUN, WAIT_HI, WAIT_LO, DONE
    } state_t;

    state_t      state, state_nx;
    logic        armed;          // low until the first clock after reset release
    logic [4:0]  nrows, ncols;
    logic        last;
    logic [4:0]  row_cnt;        // rows completed in the current matrix
    logic [3:0]  col_cnt;
    logic [15:0] row_word;
    logic [12:0] addr_cnt;       // bit 12 set once address 12'hFFF has been written
    logic        wr_req, err_set, take_hdr, take_pix;
    logic [15:0] wr_val;
    logic        hdr_legal, row_end;
    logic [15:0] pix_bit;

    assign cfg_ready = armed && (state == IDLE);
    assign pix_ready = (state == ROWS) && !ld_sram_write_enable;
    assign done      = (state == DONE);
    assign hdr_legal = (cfg_nrows != 5'd0) && (cfg_nrows <= 5'd16) &&
                       (cfg_ncols != 5'd0) && (cfg_ncols <= 5'd16);
    assign pix_bit   = pix_data ? (16'd1 << col_cnt) : 16'd0;
    assign row_end   = ({1'b0, col_cnt} == (ncols - 5'd1));

`ifdef LOADER_AUTORUN_EN
    assign dut_run = (state == RUN);
`else
    logic unused_busy;
    assign dut_run     = 1'b0;
    assign unused_busy = dut_busy;
`endif

    // Next-state, write request and bookkeeping strobes
    always_comb begin
        state_nx = state;
        wr_req   = 1'b0;
        wr_val   = 16'd0;
        err_set  = 1'b0;
        take_hdr = 1'b0;
        take_pix = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (hdr_legal) begin
                        take_hdr = 1'b1;
                        wr_req   = 1'b1;
                        wr_val   = {11'd0, cfg_nrows};
                        state_nx = HDR_R;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            HDR_R: begin
                wr_req   = 1'b1;
                wr_val   = {11'd0, ncols};
                state_nx = HDR_C;
            end
            HDR_C: state_nx = ROWS;
            ROWS: begin
                // A row write is on the bus this cycle: pause pixels and decide what follows
                if (ld_sram_write_enable) begin
                    if (row_cnt == nrows) begin
                        if (last) begin
                            wr_req   = 1'b1;
                            wr_val   = 16'h00FF;
                            state_nx = TERM;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end else if (pix_valid) begin
                    take_pix = 1'b1;
                    if (row_end) begin
                        wr_req = 1'b1;
                        wr_val = row_word | pix_bit;
                    end
                end
            end
`ifdef LOADER_AUTORUN_EN
            TERM:    state_nx = RUN;
            RUN:     state_nx = WAIT_HI;
            WAIT_HI: if (dut_busy)  state_nx = WAIT_LO;
            WAIT_LO: if (!dut_busy) state_nx = DONE;
`else
            TERM:    state_nx = DONE;
`endif
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        // Address space exhausted: drop the write and stop rather than wrap
        if (wr_req && addr_cnt[12]) begin
            wr_req   = 1'b0;
            err_set  = 1'b1;
            state_nx = DONE;
        end
    end

    // State register, sticky error and header/row bookkeeping
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            armed    <= 1'b0;
            error    <= 1'b0;
            nrows    <= 5'd0;
            ncols    <= 5'd0;
            last     <= 1'b0;
            row_cnt  <= 5'd0;
            col_cnt  <= 4'd0;
            row_word <= 16'd0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (err_set)
                error <= 1'b1;
            if (take_hdr) begin
                nrows    <= cfg_nrows;
                ncols    <= cfg_ncols;
                last     <= cfg_last;
                row_cnt  <= 5'd0;
                col_cnt  <= 4'd0;
                row_word <= 16'd0;
            end
            if (take_pix) begin
                if (row_end) begin
                    row_word <= 16'd0;
                    col_cnt  <= 4'd0;
                    row_cnt  <= row_cnt + 5'd1;
                end else begin
                    row_word <= row_word | pix_bit;
                    col_cnt  <= col_cnt + 4'd1;
                end
            end
        end
    end

    // Registered SRAM write port; address/data only move when a new write issues
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ld_sram_write_enable  <= 1'b0;
            ld_sram_write_address <= 12'd0;
            ld_sram_write_data    <= 16'd0;
            addr_cnt              <= 13'd0;
        end else begin
            ld_sram_write_enable <= wr_req;
            if (wr_req) begin
                ld_sram_write_address <= addr_cnt[11:0];
                ld_sram_write_data    <= wr_val;
                addr_cnt              <= addr_cnt + 13'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_input_loader.sv
// tb_conv_input_loader: random and directed loads checked against a word-level model.
// Latency: expected writes are queued per matrix and matched in order as they appear.
// Backpressure: pixels are offered with optional random valid gaps.
`timescale 1ns/1ps
module tb_conv_input_loader;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        cfg_valid = 1'b0, cfg_last = 1'b0;
    logic [4:0]  cfg_nrows = 5'd0, cfg_ncols = 5'd0;
    logic        pix_valid = 1'b0, pix_data = 1'b0;
    logic        dut_busy = 1'b0;
    logic        cfg_ready, pix_ready, we, dut_run, done, error;
    logic [11:0] waddr;
    logic [15:0] wdata;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_a[$];
    logic [15:0] exp_d[$];
    int          model_addr = 0;
    logic [15:0] log_data[64];
    logic [11:0] log_addr[64];
    int          nlog = 0;
    int          run_cnt = 0;
    bit          pix_mat[16][16];

    conv_input_loader dut (
        .clk(clk), .reset_b(reset_b),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_nrows(cfg_nrows), .cfg_ncols(cfg_ncols), .cfg_last(cfg_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .ld_sram_write_address(waddr), .ld_sram_write_data(wdata),
        .ld_sram_write_enable(we),
        .dut_run(dut_run), .dut_busy(dut_busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every SRAM write must be the next word the model predicts
    always @(negedge clk) begin
        if (!reset_b) begin
            nlog = 0;
            run_cnt = 0;
        end else begin
`ifndef LOADER_AUTORUN_EN
            chk("dut_run_stays_low", {31'd0, dut_run}, 32'd0);
`endif
            if (dut_run) run_cnt++;
            if (we) begin
                if (nlog < 64) begin
                    log_addr[nlog] = waddr;
                    log_data[nlog] = wdata;
                end
                nlog++;
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", waddr, wdata);
                end else begin
                    chk("wr_addr", {20'd0, waddr}, {20'd0, exp_a.pop_front()});
                    chk("wr_data", {16'd0, wdata}, {16'd0, exp_d.pop_front()});
                end
            end
        end
    end

`ifdef LOADER_AUTORUN_EN
    // Convolution DUT stand-in: busy 3 cycles after the run pulse, for 10 cycles
    always begin
        @(negedge clk);
        if (dut_run) begin
            repeat (3) @(posedge clk);
            #1 dut_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 dut_busy = 1'b0;
            chk("done_not_before_busy_fall", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1 chk("done_one_cycle_after_busy_fall", {31'd0, done}, 32'd1);
        end
    end
`endif

    // Model: a word is expected only while the address space has room
    task automatic model_write(input logic [15:0] d);
        if (model_addr <= 4095) begin
            exp_a.push_back(model_addr[11:0]);
            exp_d.push_back(d);
            model_addr++;
        end
    endtask

    task automatic model_matrix(input int nr, input int nc, input bit lst);
        int w;
        model_write(16'(nr));
        model_write(16'(nc));
        for (int r = 0; r < nr; r++) begin
            w = 0;
            for (int c = 0; c < nc; c++)
                if (pix_mat[r][c]) w = w + (1 << c);
            model_write(16'(w));
        end
        if (lst) model_write(16'h00FF);
    endtask

    task automatic assert_reset();
        reset_b = 1'b0;
        exp_a.delete();
        exp_d.delete();
        model_addr = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input int nr, input int nc, input bit lst);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_nrows = nr[4:0];
        cfg_ncols = nc[4:0];
        cfg_last  = lst;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_ready && n < 100);
        chk("cfg_handshake", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic send_pix(input bit b, input bit rnd);
        int n = 0;
        bit sent = 0;
        pix_data = b;
        while (!sent && n < 200) begin
            pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            sent = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            n++;
        end
        pix_valid = 1'b0;
        if (!sent) begin
            checks++;
            errors++;
            $display("FAIL pix_handshake: pixel not accepted within 200 cycles");
        end
    endtask

    task automatic load(input int nr, input int nc, input bit lst, input bit rnd);
        model_matrix(nr, nc, lst);
        send_hdr(nr, nc, lst);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                if (!done) send_pix(pix_mat[r][c], rnd);
    endtask

    task automatic fill_rand(input int nr, input int nc);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                pix_mat[r][c] = (r < nr && c < nc) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_a.size() != 0 && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        chk("expected_writes_left", exp_a.size(), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("done_level", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_log(input string name, input int i, input logic [15:0] d);
        chk({name, "_addr"}, {20'd0, log_addr[i]}, i);
        chk({name, "_data"}, {16'd0, log_data[i]}, {16'd0, d});
    endtask

    initial begin
        logic [15:0] lit27[6];
        logic [15:0] lit28[8];
        lit27 = '{16'h0003, 16'h0003, 16'h0005, 16'h0002, 16'h0007, 16'h00FF};
        lit28 = '{16'h0002, 16'h0010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 16'h00FF};

        // Reset values while held, then cfg_ready one clock after release
        #12;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wdata", {16'd0, wdata}, 32'd0);
        chk("rst_waddr", {20'd0, waddr}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        chk("rst_done_error", {30'd0, done, error}, 32'd0);
        release_reset();
        chk("cfg_ready_after_release", {31'd0, cfg_ready}, 32'd1);

        // 3x3 single matrix
        pix_mat = '{default: '{default: 1'b0}};
        pix_mat[0][0] = 1; pix_mat[0][2] = 1; pix_mat[1][1] = 1;
        pix_mat[2][0] = 1; pix_mat[2][1] = 1; pix_mat[2][2] = 1;
        load(3, 3, 1'b1, 1'b0);
        wait_drain();
        wait_done();
        for (int i = 0; i < 6; i++) chk_log("m3x3", i, lit27[i]);
        chk("m3x3_nwrites", nlog, 6);

        // 2x16 all ones (not last) then 1x1 zero (last)
        assert_reset();
        release_reset();
        pix_mat = '{default: '{default: 1'b1}};
        load(2, 16, 1'b0, 1'b0);
        wait_drain();
        chk("between_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("between_pix_ready", {31'd0, pix_ready}, 32'd0);
        chk("between_done", {31'd0, done}, 32'd0);
        pix_mat[0][0] = 0;
        load(1, 1, 1'b1, 1'b0);
        wait_drain();
        wait_done();
        for (int i = 0; i < 8; i++) chk_log("two_mat", i, lit28[i]);

        // Stray pixels in IDLE, illegal header, then a legal 1x1
        assert_reset();
        release_reset();
        pix_valid = 1'b1;
        pix_data  = 1'b1;
        repeat (3) @(posedge clk);
        #1 pix_valid = 1'b0;
        send_hdr(0, 3, 1'b1);
        chk("illegal_error", {31'd0, error}, 32'd1);
        chk("illegal_stays_idle", {31'd0, cfg_ready}, 32'd1);
        chk("illegal_no_write", nlog, 0);
        pix_mat[0][0] = 1;
        load(1, 1, 1'b1, 1'b0);
        wait_drain();
        wait_done();
        chk_log("after_illegal", 0, 16'h0001);
        chk_log("after_illegal", 2, 16'h0001);
        chk_log("after_illegal", 3, 16'h00FF);
        chk("error_sticky", {31'd0, error}, 32'd1);

        // Reset after 5 pixels of a 4x4, then reload from address 0
        assert_reset();
        release_reset();
        fill_rand(4, 4);
        model_matrix(4, 4, 1'b0);
        send_hdr(4, 4, 1'b0);
        for (int i = 0; i < 5; i++) send_pix(pix_mat[i / 4][i % 4], 1'b0);
        #2 assert_reset();
        #1;
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_wdata_waddr", {4'd0, wdata, waddr}, 32'd0);
        chk("midrst_readies", {30'd0, cfg_ready, pix_ready}, 32'd0);
        chk("midrst_flags", {29'd0, done, error, dut_run}, 32'd0);
        release_reset();
        fill_rand(2, 2);
        load(2, 2, 1'b1, 1'b1);
        wait_drain();
        wait_done();
        chk_log("reload", 0, 16'h0002);

`ifdef LOADER_AUTORUN_EN
        // Run pulse for a 1x1 batch
        assert_reset();
        release_reset();
        fill_rand(1, 1);
        load(1, 1, 1'b1, 1'b0);
        wait_drain();
        wait_done();
        chk("run_pulse_cycles", run_cnt, 1);
`endif

        // 16x16 with random valid gaps, then random-sized matrices
        assert_reset();
        release_reset();
        fill_rand(16, 16);
        load(16, 16, 1'b0, 1'b1);
        wait_drain();
        for (int k = 0; k < 4; k++) begin
            int nr, nc;
            nr = $urandom_range(1, 16);
            nc = $urandom_range(1, 16);
            fill_rand(nr, nc);
            load(nr, nc, k == 3, 1'b1);
            wait_drain();
        end
        wait_done();
        chk("random_no_error", {31'd0, error}, 32'd0);

        // Fill the whole address space with 16x1 matrices and overrun it
        assert_reset();
        release_reset();
        for (int m = 0; m < 228; m++) begin
            fill_rand(16, 1);
            load(16, 1, m == 227, 1'b0);
        end
        wait_drain();
        wait_done();
        chk("overflow_error", {31'd0, error}, 32'd1);
        chk("overflow_nwrites", nlog, 4096);
        repeat (3) @(posedge clk);
        #1 chk("overflow_no_more_writes", nlog, 4096);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_input_loader.md
CONV_INPUT_LOADER -- requirements
Module: conv_input_loader

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising-edge; reset_b  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: cfg_valid  in  1  matrix header offered; cfg_ready  out  1  header accepted when both are high.
REQ-003 SHALL have ports: cfg_nrows  in  5  row count, legal 1..16; cfg_ncols  in  5  column count, legal 1..16; cfg_last  in  1  matrix is last of batch.
REQ-004 SHALL have ports: pix_valid  in  1; pix_ready  out  1; pix_data  in  1  pixel, row-major order, column 0 first.
REQ-005 SHALL have ports: ld_sram_write_address  out  12; ld_sram_write_data  out  16; ld_sram_write_enable  out  1  one write per high cycle.
REQ-006 SHALL have ports: dut_run  out  1  start pulse to the convolution DUT; dut_busy  in  1  DUT busy flag.
REQ-007 SHALL have ports: done  out  1  batch complete, level; error  out  1  sticky fault flag.

Function
REQ-008 SHALL implement states IDLE, HDR_R, HDR_C, ROWS, TERM, RUN, WAIT_HI, WAIT_LO, DONE.
REQ-009 cfg_ready SHALL be high only in IDLE; pix_ready SHALL be high only in ROWS.
REQ-010 Header handshake in IDLE with legal dims SHALL latch nrows, ncols, last and go to HDR_R.
REQ-011 Illegal dims (0 or >16) SHALL set error, write nothing, and keep IDLE.
REQ-012 HDR_R SHALL write zero-extended nrows; HDR_C SHALL write zero-extended ncols. Each write takes one cycle; then go to ROWS.
REQ-013 Memory layout per matrix SHALL be: nrows word, ncols word, then nrows row words. Matrices SHALL be packed contiguously.
REQ-014 In ROWS, each accepted pixel SHALL set bit[column] of the row shift word, LSB = column 0. Bits >= ncols SHALL be 0.
REQ-015 On acceptance of column ncols-1, the completed row word SHALL be written on the next cycle. The row word register SHALL clear for the next row. pix_ready SHALL drop for that write cycle.
REQ-016 After the last row write, the FSM SHALL go to TERM if last=1, else to IDLE for the next header.
REQ-017 TERM SHALL write 16'h00FF as the batch terminator.
REQ-018 The write address SHALL start at 0 after reset and increment by 1 after every write.
REQ-019 A write needed at address 12'hFFF SHALL still be performed. Any further needed write SHALL instead set error and go to DONE without wrapping.
REQ-020 All SRAM outputs SHALL be registered. write_data and write_address SHALL be held stable while write_enable is high.
REQ-021 DONE SHALL hold done=1. A new cfg handshake is not accepted in DONE; only reset leaves DONE.
REQ-022 A pix_valid in any state other than ROWS SHALL be ignored.

Reset
REQ-023 Asserting reset_b low at any time, including mid-row, SHALL asynchronously clear all of the following:
- state to IDLE;
- address, row word, and all counters to 0;
- cfg_ready and pix_ready to 0;
- write_enable and write_data to 0;
- dut_run, done, and error to 0.
REQ-024 cfg_ready SHALL go high in the first cycle after reset release. A partially loaded matrix SHALL be discarded.

Configuration
REQ-025 Macro LOADER_AUTORUN_EN, when defined, SHALL enable the run sequence:
- TERM goes to RUN, which drives dut_run=1 for exactly one cycle;
- WAIT_HI then waits for dut_busy=1, and WAIT_LO waits for dut_busy=0;
- the FSM then goes to DONE.
REQ-026 Without LOADER_AUTORUN_EN, TERM SHALL go directly to DONE. dut_run SHALL be constant 0 and dut_busy SHALL be unused. RUN, WAIT_HI and WAIT_LO SHALL be unreachable.

Verification
REQ-027 Single matrix, 3x3, last=1, pixels 1,0,1 / 0,1,0 / 1,1,1 -> writes in order:
- addr0=0003, addr1=0003;
- addr2=0005, addr3=0002, addr4=0007;
- addr5=00FF;
- then done=1.
REQ-028 Two matrices, 2x16 all-ones with last=0, then 1x1 pixel 0 with last=1 -> writes in order:
- addr0..3 = 0002, 0010, FFFF, FFFF;
- addr4..6 = 0001, 0001, 0000;
- addr7 = 00FF.
REQ-029 Header with nrows=0, then a legal 1x1 header -> error=1 and no write for the first header; the second loads normally at addr0.
REQ-030 Reset pulsed after 5 pixels of a 4x4 matrix -> all outputs reach their reset values immediately; a reloaded matrix starts at addr0.
REQ-031 With LOADER_AUTORUN_EN and a 1x1 matrix, dut_busy driven high 3 cycles after dut_run and low 10 cycles later -> dut_run is high exactly 1 cycle; done rises 1 cycle after dut_busy falls.
REQ-032 pix_valid toggled randomly with a 50% duty cycle during a 16x16 load -> row words match a reference model; no pixel is dropped or duplicated.
